// File: rtl/ab_eval_sequencer_pkg.sv
// Shared types for the Bulls-and-Cows guess scorer: FSM states, history entry
// layout and the digit-array packing helper.
package ab_eval_sequencer_pkg;

    localparam int HIST_DEPTH_DEF = 5;
    localparam int DIGITS_DEF     = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_COMMIT
    } eval_state_t;

    // Entry layout is {guess 16b, a 3b, b 4b}; digit 3 lands in the top nibble
    typedef struct packed {
        logic [3:0][3:0] g;
        logic [2:0]      a;
        logic [3:0]      b;
    } hist_entry_t;

    function automatic logic [15:0] pack_code(input logic [3:0] d [3:0]);
        return {d[3], d[2], d[1], d[0]};
    endfunction

endpackage

// File: rtl/ab_eval_sequencer_if.sv
// Request/result bundle between the game FSM (master) and the scorer (slave).
interface ab_eval_sequencer_if;
    logic        start;
    logic        clear;
    logic [3:0]  target [3:0];
    logic [3:0]  guess  [3:0];
    logic        busy;
    logic        done;
    logic [2:0]  a_cnt;
    logic [3:0]  b_cnt;
    logic        win;
    logic [2:0]  hist_count;
    logic [2:0]  hist_rd_idx;
    logic [22:0] hist_rd_data;

    modport master (
        output start, clear, target, guess, hist_rd_idx,
        input  busy, done, a_cnt, b_cnt, win, hist_count, hist_rd_data
    );

    modport slave (
        input  start, clear, target, guess, hist_rd_idx,
        output busy, done, a_cnt, b_cnt, win, hist_count, hist_rd_data
    );
endinterface

// File: rtl/ab_eval_sequencer_history_buf.sv
// Circular history of scored guesses with a registered, oldest-first read port.
module ab_history_buf
    import ab_eval_sequencer_pkg::*;
#(
    parameter int HIST_DEPTH = HIST_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        wr_en,
    input  hist_entry_t wr_data,
    input  logic [2:0]  rd_idx,
    output logic [2:0]  count,
    output hist_entry_t rd_data
);

    hist_entry_t mem [HIST_DEPTH];
    logic [2:0]  wr_ptr;
    logic [2:0]  oldest;
    logic [3:0]  rd_sum;
    logic [2:0]  rd_phys;

    // Once full, the write pointer sits on the oldest entry, so logical index 0 follows it
    always_comb begin
        oldest  = (count == 3'(HIST_DEPTH)) ? wr_ptr : 3'd0;
        rd_sum  = {1'b0, oldest} + {1'b0, rd_idx};
        rd_phys = (rd_sum >= 4'(HIST_DEPTH)) ? 3'(rd_sum - 4'(HIST_DEPTH)) : rd_sum[2:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
            for (int e = 0; e < HIST_DEPTH; e++) begin
                mem[e] <= '0;
            end
        end else begin
            rd_data <= (rd_idx < count) ? mem[rd_phys] : '0;
            if (clear) begin
                wr_ptr <= '0;
                count  <= '0;
            end else if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= (wr_ptr == 3'(HIST_DEPTH - 1)) ? 3'd0 : wr_ptr + 3'd1;
                if (count != 3'(HIST_DEPTH)) begin
                    count <= count + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ab_eval_sequencer.sv
// Scores a guess against the target by walking all 16 digit pairs through one
// shared comparator, then commits the A/B result into the history buffer.
module ab_eval_sequencer
    import ab_eval_sequencer_pkg::*;
#(
    parameter int HIST_DEPTH = HIST_DEPTH_DEF,
    parameter int DIGITS     = DIGITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    ab_eval_sequencer_if.slave  bus
);

    localparam logic [3:0] LAST_PAIR = 4'(DIGITS * DIGITS - 1);

    eval_state_t state;
    logic [3:0]  idx;
    logic [2:0]  a_acc;
    logic [3:0]  b_acc;
    logic [3:0]  tgt_q [3:0];
    logic [3:0]  gs_q  [3:0];
    logic        busy_q;
    logic        done_q;
    logic [2:0]  a_q;
    logic [3:0]  b_q;
    logic        win_q;
    logic        pair_match;
    logic        same_pos;
    logic        hist_wr_en;
    hist_entry_t wr_entry;
    hist_entry_t rd_entry;

    // idx[3:2] picks the guess digit, idx[1:0] the target digit
    always_comb begin
        pair_match = (gs_q[idx[3:2]] == tgt_q[idx[1:0]]);
        same_pos   = (idx[3:2] == idx[1:0]);
        hist_wr_en = (state == S_COMMIT) && !bus.clear;
        wr_entry   = '0;
        wr_entry.g = pack_code(gs_q);
        wr_entry.a = a_acc;
        wr_entry.b = b_acc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            a_acc  <= '0;
            b_acc  <= '0;
            tgt_q  <= '{default: '0};
            gs_q   <= '{default: '0};
            busy_q <= 1'b0;
            done_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            win_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.clear) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
                a_q    <= '0;
                b_q    <= '0;
                win_q  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            tgt_q  <= bus.target;
                            gs_q   <= bus.guess;
                            a_acc  <= '0;
                            b_acc  <= '0;
                            idx    <= '0;
                            busy_q <= 1'b1;
                            state  <= S_COMPARE;
                        end
                    end
                    S_COMPARE: begin
                        if (pair_match) begin
                            if (same_pos) begin
                                a_acc <= a_acc + 3'd1;
                            end else begin
                                b_acc <= b_acc + 4'd1;
                            end
                        end
                        idx <= idx + 4'd1;
                        if (idx == LAST_PAIR) begin
                            state <= S_COMMIT;
                        end
                    end
                    S_COMMIT: begin
                        a_q    <= a_acc;
                        b_q    <= b_acc;
                        win_q  <= (a_acc == 3'd4);
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    ab_history_buf #(
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.clear),
        .wr_en   (hist_wr_en),
        .wr_data (wr_entry),
        .rd_idx  (bus.hist_rd_idx),
        .count   (bus.hist_count),
        .rd_data (rd_entry)
    );

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.a_cnt        = a_q;
    assign bus.b_cnt        = b_q;
    assign bus.win          = win_q;
    assign bus.hist_rd_data = rd_entry;

endmodule

// File: tb/tb_ab_eval_sequencer.sv
// Scoreboard bench for ab_eval_sequencer: directed guesses push expected results,
// a monitor pops them whenever done pulses.
module tb_ab_eval_sequencer;

    typedef struct {
        logic [2:0] a;
        logic [3:0] b;
        logic       win;
        int         done_cyc;
    } expect_t;

    logic    clk;
    logic    reset;
    int      cyc;
    int      n_vec;
    int      n_miss;
    expect_t sb_q [$];

    ab_eval_sequencer_if bus ();

    ab_eval_sequencer #(
        .HIST_DEPTH (5),
        .DIGITS     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic set_codes(input logic [15:0] t, input logic [15:0] g);
        for (int d = 0; d < 4; d++) begin
            bus.target[d] = t[4*d +: 4];
            bus.guess[d]  = g[4*d +: 4];
        end
    endtask

    task automatic push_expect(input logic [2:0] a, input logic [3:0] b, input int drive_cyc);
        expect_t e;
        e.a        = a;
        e.b        = b;
        e.win      = (a == 3'd4);
        e.done_cyc = drive_cyc + 18;
        sb_q.push_back(e);
    endtask

    // Pulse start with the given codes and wait until the result has settled
    task automatic apply_stimulus(input logic [15:0] t, input logic [15:0] g,
                                  input logic [2:0] a, input logic [3:0] b);
        @(negedge clk);
        set_codes(t, g);
        bus.start = 1'b1;
        push_expect(a, b, cyc);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (18) @(negedge clk);
    endtask

    task automatic read_hist(input logic [2:0] idx, input logic [22:0] req, input string name);
        @(negedge clk);
        bus.hist_rd_idx = idx;
        @(negedge clk);
        check_output(name, 32'(bus.hist_rd_data), 32'(req));
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_busy"},  32'(bus.busy),         32'd0);
        check_output({tag, "_done"},  32'(bus.done),         32'd0);
        check_output({tag, "_a"},     32'(bus.a_cnt),        32'd0);
        check_output({tag, "_b"},     32'(bus.b_cnt),        32'd0);
        check_output({tag, "_win"},   32'(bus.win),          32'd0);
        check_output({tag, "_count"}, 32'(bus.hist_count),   32'd0);
        check_output({tag, "_rd"},    32'(bus.hist_rd_data), 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no result (cycle %0d)", cyc);
            end else begin
                expect_t e;
                e = sb_q.pop_front();
                check_output("done_cycle", 32'(cyc),       32'(e.done_cyc));
                check_output("a_cnt",      32'(bus.a_cnt), 32'(e.a));
                check_output("b_cnt",      32'(bus.b_cnt), 32'(e.b));
                check_output("win",        32'(bus.win),   32'(e.win));
            end
        end
    end

    initial begin
        int n;
        cyc             = 0;
        n_vec           = 0;
        n_miss          = 0;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.clear       = 1'b0;
        bus.hist_rd_idx = 3'd0;
        set_codes(16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        apply_stimulus(16'h1234, 16'h1234, 3'd4, 4'd0);
        check_output("hist_count_1", 32'(bus.hist_count), 32'd1);
        apply_stimulus(16'h1234, 16'h4321, 3'd0, 4'd4);
        apply_stimulus(16'h5678, 16'h1234, 3'd0, 4'd0);
        apply_stimulus(16'h1111, 16'h1111, 3'd4, 4'd12);
        check_output("hist_count_4", 32'(bus.hist_count), 32'd4);

        // Snapshot check plus a second start while busy
        @(negedge clk);
        set_codes(16'h1234, 16'h1243);
        bus.start = 1'b1;
        n = cyc;
        push_expect(3'd2, 4'd2, n);
        for (int s = 1; s <= 19; s++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (s == 1) begin
                set_codes(16'h1234, 16'h9999);
                check_output("busy_after_start", 32'(bus.busy), 32'd1);
            end
            if (s == 5) begin
                bus.start = 1'b1;
            end
            if (s == 17) check_output("busy_last_cycle", 32'(bus.busy), 32'd1);
            if (s == 18) check_output("busy_released",   32'(bus.busy), 32'd0);
        end
        check_output("hist_count_5", 32'(bus.hist_count), 32'd5);

        apply_stimulus(16'h5678, 16'h5678, 3'd4, 4'd0);
        check_output("hist_count_sat", 32'(bus.hist_count), 32'd5);
        read_hist(3'd0, {16'h4321, 3'd0, 4'd4},  "hist_idx0");
        read_hist(3'd1, {16'h1234, 3'd0, 4'd0},  "hist_idx1");
        read_hist(3'd3, {16'h1243, 3'd2, 4'd2},  "hist_idx3");
        read_hist(3'd4, {16'h5678, 3'd4, 4'd0},  "hist_idx4");
        read_hist(3'd5, 23'd0,                   "hist_idx5");

        // Clear in the middle of an evaluation
        @(negedge clk);
        set_codes(16'h1234, 16'h1234);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check_output("clear_busy",  32'(bus.busy),       32'd0);
        check_output("clear_count", 32'(bus.hist_count), 32'd0);
        check_output("clear_a",     32'(bus.a_cnt),      32'd0);
        check_output("clear_win",   32'(bus.win),        32'd0);
        repeat (12) @(negedge clk);
        read_hist(3'd0, 23'd0, "clear_hist_idx0");

        // clear and start together: start is dropped
        @(negedge clk);
        bus.clear = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        bus.start = 1'b0;
        check_output("clear_start_busy", 32'(bus.busy), 32'd0);
        repeat (18) @(negedge clk);

        apply_stimulus(16'h9876, 16'h6789, 3'd0, 4'd4);
        check_output("post_clear_count", 32'(bus.hist_count), 32'd1);

        // Reset in the middle of an evaluation
        @(negedge clk);
        set_codes(16'h1234, 16'h1234);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        check_output("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ab_eval_sequencer.md
Name: ab_eval_sequencer

Overview:
- Scores one Bulls-and-Cows guess against the target: A = right digit in the right place, B = right digit in the wrong place.
- Sits beside game_core. Takes the stored target and guess arrays and a start pulse from the game FSM.
- Walks all 16 digit pairs through one shared 4-bit comparator, one pair per cycle.
- Keeps a short history of scored guesses that the display logic reads back.

Parameters:
- HIST_DEPTH, 5: number of history entries kept (one per chance).
- DIGITS, 4: digits per code. Fixed at 4; the compare counter assumes 16 pairs.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; request to score the current guess.
- clear  in  1  one-cycle pulse; new game, flush the history.
- target  in  4x4  unpacked [3:0] array of 4-bit digits; the answer.
- guess  in  4x4  unpacked [3:0] array of 4-bit digits; the guess.
- busy  out  1  high while an evaluation is in progress.
- done  out  1  one-cycle pulse when a result is committed.
- a_cnt  out  3  A count of the last result (0..4).
- b_cnt  out  4  B count of the last result (0..12).
- win  out  1  a_cnt == 4, registered together with a_cnt.
- hist_count  out  3  valid history entries (0..HIST_DEPTH).
- hist_rd_idx  in  3  history read index; 0 = oldest.
- hist_rd_data  out  23  {guess 16b, a 3b, b 4b}; registered one cycle after the index.

Behaviour:
- Reset: all outputs are 0, state is S_IDLE, history is empty.
- States: S_IDLE, S_COMPARE, S_COMMIT.
- S_IDLE:
  - start=1 snapshots target and guess into internal registers, zeroes the A/B accumulators and the pair index (0..15), and goes to S_COMPARE.
  - Inputs may change after the start edge; the evaluation uses the snapshot only.
- S_COMPARE, one pair per edge:
  - i = idx[3:2] selects the guess digit; j = idx[1:0] selects the target digit.
  - If the digits are equal: A++ when i==j, otherwise B++.
  - After idx 15, go to S_COMMIT.
- S_COMMIT, one cycle:
  - Register a_cnt, b_cnt and win; pulse done=1 for one cycle; write a history entry.
  - Return to S_IDLE.
- Timing:
  - start sampled at edge k → busy high from edge k to edge k+17.
  - done and the new a_cnt/b_cnt become visible after edge k+17.
  - Total latency is 17 cycles.
- Result outputs hold their value until the next commit or until clear.
- Duplicate digits are not rejected here. Counts are pair counts: target 1111 vs guess 1111 gives A=4, B=12.
- start while busy is ignored and not queued.
- clear:
  - Highest priority after reset.
  - Aborts any evaluation: no done, no history write.
  - Zeroes a_cnt, b_cnt, win and hist_count, and goes to S_IDLE.
  - clear and start in the same cycle: clear wins and start is dropped.
- History:
  - Circular buffer.
  - When not full, a commit appends and hist_count increments.
  - When full, a commit overwrites the oldest entry and hist_count stays at HIST_DEPTH; index 0 then maps to the next-oldest entry.
- Reads:
  - hist_rd_idx ≥ hist_count returns all zeros.
  - A read of the index being written in the same cycle returns the old content.
- Reset in the middle of an evaluation returns everything to the reset values.

Decomposition:
- game_types additions:
  - eval_state_t (S_IDLE / S_COMPARE / S_COMMIT).
  - HIST_DEPTH_DEF = 5.
  - hist_entry_t packed struct {logic [3:0] g[4]; logic [2:0] a; logic [3:0] b}, 23 bits.
- Sub-module ab_history_buf:
  - Owns the circular buffer, pointers, count saturation, clear, and the registered read port.
  - The parent keeps the FSM, the comparator and the counters.

Test Plan:
- Target 1234, guess 1234, start at edge k → done at k+17; a=4, b=0, win=1; hist_count=1.
- Target 1234, guess 4321 → a=0, b=4, win=0. Target 5678, guess 1234 → a=0, b=0.
- Target 1234, guess 1243; change guess to 9999 one cycle after start → result still a=2, b=2, because the snapshot is used.
- Pulse start again at k+5 → ignored; exactly one done, at k+17.
- Six commits with guesses G1..G6 → hist_count=5; idx0 reads G2 one cycle later; idx5 reads 0.
- Assert clear at k+8 → no done; busy low next cycle; hist_count=0. Assert reset at k+8 → all outputs 0.
